// File: rtl/pipe_stage_reg_pkg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg_pkg
//
// Purpose:
//   Shared definitions for the generic pipeline stage register.
//   - Stall-bus index constants. Each boundary instance picks its stall_up and
//     stall_down bits from the stall vector by name.
//   - Payload widths for each stage boundary. The payload is packed and
//     unpacked at the instantiation site, so these values set WIDTH there.
//   - The default event-counter width.
//   - The per-edge action encoding and the priority decode that selects it.
//
// Ports: none (package).
// ---------------------------------------------------------------------------
package pipe_stage_reg_pkg;

    // Bit positions inside the core stall vector, ordered from fetch to
    // writeback. A boundary between stage N and stage N+1 uses bit N as
    // stall_up and bit N+1 as stall_down.
    localparam int StallIf   = 0;
    localparam int StallId   = 1;
    localparam int StallEx   = 2;
    localparam int StallMem  = 3;
    localparam int StallWb   = 4;
    localparam int StallBusW = 5;

    // Payload widths for each boundary, in bits.
    localparam int IfIdWidth  = 64;
    localparam int IdExWidth  = 128;
    localparam int ExMemWidth = 96;
    localparam int MemWbWidth = 72;

    // Default width of the bubble and flush event counters.
    localparam int DefaultCntW = 16;

    // The action that the stage register performs on one rising edge. Reset
    // is handled separately because it also clears the counters.
    typedef enum logic [1:0] {
        ActLoad   = 2'd0,
        ActHold   = 2'd1,
        ActBubble = 2'd2,
        ActFlush  = 2'd3
    } stage_act_e;

    // Priority decode of the control inputs.
    // - Flush beats both stalls.
    // - A downstream stall beats an upstream stall, because the consumer
    //   still needs the instruction that this register holds.
    function automatic stage_act_e decodeAction(
        input logic flushIn,
        input logic stallUp,
        input logic stallDown
    );
        if (flushIn) begin
            return ActFlush;
        end
        if (stallDown) begin
            return ActHold;
        end
        if (stallUp) begin
            return ActBubble;
        end
        return ActLoad;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//
// Purpose:
//   Saturating up-counter for performance-debug event counts.
//   - It sticks at all-ones and never wraps.
//   - A synchronous clear wins over an increment in the same cycle.
//   - The active-low synchronous reset wins over everything.
//
// Ports:
//   clock    in   1   rising-edge clock
//   reset_n  in   1   synchronous active-low reset, clears count
//   clr      in   1   synchronous clear, priority over inc
//   inc      in   1   count one event this cycle
//   count    out  W   registered count value
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] countQ;
    logic [W-1:0] countD;

    // Next-state logic for the counter.
    // - The all-ones check stops the counter from wrapping to zero.
    // - A clear in the same cycle as an increment takes precedence.
    always_comb begin
        countD = countQ;
        if (clr) begin
            countD = '0;
        end else if (inc && (countQ != {W{1'b1}})) begin
            countD = countQ + W'(1);
        end
    end

    // Counter state register. The reset is synchronous and active-low.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            countQ <= '0;
        end else begin
            countQ <= countD;
        end
    end

    assign count = countQ;

endmodule

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Purpose:
//   Generic pipeline boundary register. It carries an opaque payload and a
//   valid bit from one stage to the next.
//   - Supports flush, downstream hold and upstream bubble insertion.
//   - Keeps saturating counters of inserted bubbles and effective flushes.
//   - Every output is registered, and a load takes exactly one cycle.
//
// Parameters:
//   WIDTH         payload width in bits (>= 1)
//   CLEAR_BUBBLE  1: a bubble or flush zeroes the payload
//                 0: a bubble or flush holds the payload and clears only valid
//   CNT_W         width of each event counter (>= 1)
//
// Ports:
//   clock         in   1      rising-edge clock
//   reset_n       in   1      synchronous active-low reset
//   stall_up      in   1      producing-stage stall
//   stall_down    in   1      consuming-stage stall
//   flush         in   1      kill the held instruction
//   cnt_clr       in   1      synchronous clear of both counters
//   valid_i       in   1      producer payload is a real instruction
//   data_i        in   WIDTH  producer payload
//   valid_o       out  1      registered valid
//   data_o        out  WIDTH  registered payload
//   bubble_cnt_o  out  CNT_W  bubbles inserted since last clear
//   flush_cnt_o   out  CNT_W  effective flushes since last clear
// ---------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int CLEAR_BUBBLE = 1,
    parameter int CNT_W        = DefaultCntW
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             stall_up,
    input  logic             stall_down,
    input  logic             flush,
    input  logic             cnt_clr,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] bubble_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    stage_act_e       act;
    logic             validQ;
    logic             validD;
    logic [WIDTH-1:0] dataQ;
    logic [WIDTH-1:0] dataD;
    logic             bubbleInc;
    logic             flushInc;

    // Select the action for this edge from the control inputs.
    assign act = decodeAction(flush, stall_up, stall_down);

    // Next-state logic for the payload and valid bit.
    // - data_i is used only on a load, so an X on data_i during a hold,
    //   bubble or flush cannot reach the register.
    // - With CLEAR_BUBBLE=0, a killed slot keeps its stale payload. This
    //   saves toggling on the payload bus.
    always_comb begin
        validD = validQ;
        dataD  = dataQ;
        case (act)
            ActLoad: begin
                validD = valid_i;
                dataD  = data_i;
            end
            ActHold: begin
                validD = validQ;
                dataD  = dataQ;
            end
            ActBubble, ActFlush: begin
                validD = 1'b0;
                if (CLEAR_BUBBLE != 0) begin
                    dataD = '0;
                end
            end
            default: begin
                validD = validQ;
                dataD  = dataQ;
            end
        endcase
    end

    // Stage register. The reset is synchronous and active-low, and it clears
    // the slot whether the stage is mid-stall or mid-flush.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            validQ <= 1'b0;
            dataQ  <= '0;
        end else begin
            validQ <= validD;
            dataQ  <= dataD;
        end
    end

    // Event qualification.
    // - A flush counts only when it kills a live instruction.
    // - A bubble counts every cycle that one is inserted.
    assign bubbleInc = (act == ActBubble);
    assign flushInc  = (act == ActFlush) && validQ;

    sat_counter #(
        .W(CNT_W)
    ) uBubbleCnt (
        .clock  (clock),
        .reset_n(reset_n),
        .clr    (cnt_clr),
        .inc    (bubbleInc),
        .count  (bubble_cnt_o)
    );

    sat_counter #(
        .W(CNT_W)
    ) uFlushCnt (
        .clock  (clock),
        .reset_n(reset_n),
        .clr    (cnt_clr),
        .inc    (flushInc),
        .count  (flush_cnt_o)
    );

    assign valid_o = validQ;
    assign data_o  = dataQ;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Drives three pipe_stage_reg instances from the same inputs:
//   - dutA: CLEAR_BUBBLE=1, CNT_W=16
//   - dutB: CLEAR_BUBBLE=0, CNT_W=16
//   - dutC: CLEAR_BUBBLE=1, CNT_W=3
// A behavioural model of the priority rules predicts every output.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

    logic        clock;
    logic        reset_n;
    logic        stall_up;
    logic        stall_down;
    logic        flush;
    logic        cnt_clr;
    logic        valid_i;
    logic [31:0] data_i;

    logic        validA, validB, validC;
    logic [31:0] dataA, dataB, dataC;
    logic [15:0] bubA, bubB, flA, flB;
    logic [2:0]  bubC, flC;

    int checks = 0;
    int errors = 0;

    // Reference model state, one entry per DUT.
    logic        mValid [3];
    logic [31:0] mData  [3];
    int          mBub   [3];
    int          mFl    [3];

    // Model configuration for each DUT, in the same order as the instances.
    int cfgClear [3] = '{1, 0, 1};
    int cfgMax   [3] = '{65535, 65535, 7};

    // Outputs gathered so each DUT can be indexed.
    logic [31:0] oValid [3];
    logic [31:0] oData  [3];
    logic [31:0] oBub   [3];
    logic [31:0] oFl    [3];

    assign oValid[0] = {31'd0, validA};
    assign oValid[1] = {31'd0, validB};
    assign oValid[2] = {31'd0, validC};
    assign oData[0]  = dataA;
    assign oData[1]  = dataB;
    assign oData[2]  = dataC;
    assign oBub[0]   = {16'd0, bubA};
    assign oBub[1]   = {16'd0, bubB};
    assign oBub[2]   = {29'd0, bubC};
    assign oFl[0]    = {16'd0, flA};
    assign oFl[1]    = {16'd0, flB};
    assign oFl[2]    = {29'd0, flC};

    pipe_stage_reg #(.WIDTH(32), .CLEAR_BUBBLE(1), .CNT_W(16)) dutA (
        .clock(clock), .reset_n(reset_n), .stall_up(stall_up), .stall_down(stall_down),
        .flush(flush), .cnt_clr(cnt_clr), .valid_i(valid_i), .data_i(data_i),
        .valid_o(validA), .data_o(dataA), .bubble_cnt_o(bubA), .flush_cnt_o(flA)
    );

    pipe_stage_reg #(.WIDTH(32), .CLEAR_BUBBLE(0), .CNT_W(16)) dutB (
        .clock(clock), .reset_n(reset_n), .stall_up(stall_up), .stall_down(stall_down),
        .flush(flush), .cnt_clr(cnt_clr), .valid_i(valid_i), .data_i(data_i),
        .valid_o(validB), .data_o(dataB), .bubble_cnt_o(bubB), .flush_cnt_o(flB)
    );

    pipe_stage_reg #(.WIDTH(32), .CLEAR_BUBBLE(1), .CNT_W(3)) dutC (
        .clock(clock), .reset_n(reset_n), .stall_up(stall_up), .stall_down(stall_down),
        .flush(flush), .cnt_clr(cnt_clr), .valid_i(valid_i), .data_i(data_i),
        .valid_o(validC), .data_o(dataC), .bubble_cnt_o(bubC), .flush_cnt_o(flC)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Advance the reference model by one rising edge. The rules are applied
    // in their priority order:
    //   - reset
    //   - flush
    //   - downstream hold
    //   - bubble
    //   - load
    // Counter events are judged on the valid bit from before the edge.
    task automatic modelStep();
        for (int k = 0; k < 3; k++) begin
            if (!reset_n) begin
                mValid[k] = 1'b0;
                mData[k]  = 32'd0;
                mBub[k]   = 0;
                mFl[k]    = 0;
            end else begin
                bit flushEvt  = flush && mValid[k];
                bit bubbleEvt = !flush && !stall_down && stall_up;
                if (flush || bubbleEvt) begin
                    mValid[k] = 1'b0;
                    if (cfgClear[k] == 1) mData[k] = 32'd0;
                end else if (!stall_down) begin
                    mValid[k] = valid_i;
                    mData[k]  = data_i;
                end
                if (cnt_clr) begin
                    mBub[k] = 0;
                    mFl[k]  = 0;
                end else begin
                    if (bubbleEvt && mBub[k] < cfgMax[k]) mBub[k] = mBub[k] + 1;
                    if (flushEvt && mFl[k] < cfgMax[k]) mFl[k] = mFl[k] + 1;
                end
            end
        end
    endtask

    // Drive one cycle of inputs, clock it through the DUTs and the model,
    // then move 1 unit past the edge so the outputs can be sampled.
    task automatic applyStimulus(input logic rstN, input logic su, input logic sd,
                                 input logic fl, input logic clr, input logic vi,
                                 input logic [31:0] di);
        reset_n    = rstN;
        stall_up   = su;
        stall_down = sd;
        flush      = fl;
        cnt_clr    = clr;
        valid_i    = vi;
        data_i     = di;
        @(posedge clock);
        modelStep();
        #1;
    endtask

    task automatic checkVal(input string tag, input int k,
                            input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s dut%0d: observed %h expected %h", tag, k, obs, exp);
        end
    endtask

    // Compare every output of every DUT against the model.
    task automatic checkOutput(input string tag);
        for (int k = 0; k < 3; k++) begin
            checkVal({tag, ".valid"}, k, oValid[k], {31'd0, mValid[k]});
            checkVal({tag, ".data"}, k, oData[k], mData[k]);
            checkVal({tag, ".bubcnt"}, k, oBub[k], 32'(mBub[k]));
            checkVal({tag, ".flcnt"}, k, oFl[k], 32'(mFl[k]));
        end
    endtask

    // Directed sequence first, then randomized traffic.
    initial begin
        reset_n = 1'b0; stall_up = 1'b0; stall_down = 1'b0; flush = 1'b0;
        cnt_clr = 1'b0; valid_i = 1'b0; data_i = 32'd0;
        for (int k = 0; k < 3; k++) begin
            mValid[k] = 1'b0; mData[k] = 32'd0; mBub[k] = 0; mFl[k] = 0;
        end

        // Reset for two cycles, then a plain load.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1111_1111);
        checkOutput("reset");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        checkOutput("load1");
        checkVal("load1.literal", 0, dataA, 32'hDEAD_BEEF);

        // Downstream hold: the held payload survives and no bubbles count.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1234_5678);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
        checkOutput("hold0");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        checkOutput("hold1");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        checkOutput("hold2");
        checkVal("hold.literal", 1, dataB, 32'h1234_5678);

        // Four bubbles with X on data_i, which must not leak through.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hxxxx_xxxx);
        end
        checkOutput("bubble4");
        checkVal("bubble4.literal", 0, oBub[0], 32'd4);

        // Flush wins over a downstream stall; a second flush adds nothing.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0BAD_F00D);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hxxxx_xxxx);
        checkOutput("flush1");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h5555_5555);
        checkOutput("flush2");
        checkVal("flush2.literal", 0, oFl[0], 32'd1);

        // Saturation of the 3-bit counter, then a clear beats a bubble.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        end
        checkOutput("saturate");
        checkVal("saturate.literal", 2, oBub[2], 32'd7);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("clear");

        // Reset in the middle of a bubble run, then a load.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h7777_7777);
        end
        checkOutput("bubble5");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h7777_7777);
        checkOutput("midreset");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA5A5_A5A5);
        checkOutput("postreset");

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            applyStimulus($urandom_range(0, 49) != 0,
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, 7) == 0,
                          $urandom_range(0, 19) == 0,
                          1'($urandom_range(0, 1)),
                          $urandom);
            checkOutput("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
